// File: rtl/tri_st_add_pkg.sv
// Shared constants and FSM encoding for the byte-serial adder.
package tri_st_add_pkg;

    localparam int BYTE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/tri_st_add_slice8.sv
// One byte of the adder: both carry-in cases are summed up front and the
// late-arriving carry only drives the final select.
module tri_st_add_slice8
    import tri_st_add_pkg::*;
(
    input  logic [0:BYTE-1] a,
    input  logic [0:BYTE-1] b,
    input  logic            ci,
    output logic [0:BYTE-1] sum,
    output logic            co
);

    logic [BYTE:0] w_s0;
    logic [BYTE:0] w_s1;

    assign w_s0 = {1'b0, a} + {1'b0, b};
    assign w_s1 = {1'b0, a} + {1'b0, b} + (BYTE+1)'(1);

    assign sum = ci ? w_s1[BYTE-1:0] : w_s0[BYTE-1:0];
    assign co  = ci ? w_s1[BYTE]     : w_s0[BYTE];

endmodule

// File: rtl/tri_st_add_seq.sv
// Two-requester, byte-serial adder. Operands are captured on grant, then
// added one byte per cycle from the LSB byte up; the result is presented
// for a single DONE cycle and held afterwards.
module tri_st_add_seq
    import tri_st_add_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             nclk,
    input  logic             rst,
    input  logic             r0_req,
    input  logic [0:WIDTH-1] r0_a,
    input  logic [0:WIDTH-1] r0_b,
    input  logic             r0_ci,
    input  logic             r0_sub,
    output logic             r0_gnt,
    input  logic             r1_req,
    input  logic [0:WIDTH-1] r1_a,
    input  logic [0:WIDTH-1] r1_b,
    input  logic             r1_ci,
    input  logic             r1_sub,
    output logic             r1_gnt,
    input  logic             flush,
    output logic             rsp_val,
    output logic             rsp_id,
    output logic [0:WIDTH-1] rsp_sum,
    output logic             rsp_co,
    output logic             rsp_ovf,
    output logic             busy
);

    localparam int NB = WIDTH / BYTE;
    localparam int CW = (NB > 8) ? $clog2(NB) : 3;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [0:WIDTH-1] r_a;
    logic [0:WIDTH-1] r_b;
    logic [0:WIDTH-1] r_acc;
    logic             r_cy;
    logic             r_id;
    logic             r_last;   // 1 = r1 granted last, so r0 wins a tie

    logic             w_idle_ok;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_last_beat;
    logic [0:BYTE-1]  w_byte_sum;
    logic             w_byte_co;
    logic [0:WIDTH-1] w_acc_nxt;
    logic             w_ovf;

    // Grants only from IDLE, never under flush or reset.
    assign w_idle_ok = (r_state == IDLE) & ~flush & ~rst;
    assign w_gnt0    = w_idle_ok & r0_req & (~r1_req | r_last);
    assign w_gnt1    = w_idle_ok & r1_req & (~r0_req | ~r_last);
    assign r0_gnt    = w_gnt0;
    assign r1_gnt    = w_gnt1;

    assign busy    = (r_state != IDLE);
    assign rsp_val = (r_state == DONE) & ~flush;

    assign w_last_beat = (r_cnt == CW'(NB - 1));

    tri_st_add_slice8 u_slice (
        .a   (r_a[WIDTH-BYTE:WIDTH-1]),
        .b   (r_b[WIDTH-BYTE:WIDTH-1]),
        .ci  (r_cy),
        .sum (w_byte_sum),
        .co  (w_byte_co)
    );

    // New byte enters at the MSB end; after NB beats the first byte sits at the LSB end.
    assign w_acc_nxt = WIDTH'({w_byte_sum, r_acc} >> BYTE);

    // On the last beat the slice holds the MSB byte, so its sign bits decide overflow.
    assign w_ovf = (r_a[WIDTH-BYTE] == r_b[WIDTH-BYTE]) &
                   (w_byte_sum[0] != r_a[WIDTH-BYTE]);

    // FSM, arbiter pointer, operand shifters and response registers.
    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cy    <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            rsp_id  <= 1'b0;
            rsp_sum <= '0;
            rsp_co  <= 1'b0;
            rsp_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt0 | w_gnt1) begin
                        r_a     <= w_gnt1 ? r1_a : r0_a;
                        r_b     <= w_gnt1 ? (r1_b ^ {WIDTH{r1_sub}}) : (r0_b ^ {WIDTH{r0_sub}});
                        r_cy    <= w_gnt1 ? r1_ci : r0_ci;
                        r_id    <= w_gnt1;
                        r_last  <= w_gnt1;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_a   <= r_a >> BYTE;
                        r_b   <= r_b >> BYTE;
                        r_acc <= w_acc_nxt;
                        r_cy  <= w_byte_co;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last_beat) begin
                            r_cnt   <= '0;
                            r_state <= DONE;
                            rsp_sum <= w_acc_nxt;
                            rsp_co  <= w_byte_co;
                            rsp_ovf <= w_ovf;
                            rsp_id  <= r_id;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_st_add_seq.sv
// Bench for the byte-serial adder: directed corner cases, random operands,
// round-robin streaming, and flush/reset aborts.
module tb_tri_st_add_seq;

    localparam int W  = 64;
    localparam int NB = W / 8;

    logic nclk = 1'b0;
    always #5 nclk = ~nclk;

    logic         rst, flush;
    logic         r0_req, r0_ci, r0_sub, r0_gnt;
    logic         r1_req, r1_ci, r1_sub, r1_gnt;
    logic [0:W-1] r0_a, r0_b, r1_a, r1_b, rsp_sum;
    logic         rsp_val, rsp_id, rsp_co, rsp_ovf, busy;

    int total = 0;
    int bad   = 0;

    tri_st_add_seq #(.WIDTH(W)) dut (
        .nclk(nclk), .rst(rst),
        .r0_req(r0_req), .r0_a(r0_a), .r0_b(r0_b), .r0_ci(r0_ci), .r0_sub(r0_sub), .r0_gnt(r0_gnt),
        .r1_req(r1_req), .r1_a(r1_a), .r1_b(r1_b), .r1_ci(r1_ci), .r1_sub(r1_sub), .r1_gnt(r1_gnt),
        .flush(flush), .rsp_val(rsp_val), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_co(rsp_co), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    // Reference: plain integer addition; overflow when the true signed result
    // does not survive truncation back to W bits.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic sub,
                                  output logic [W-1:0] s, output logic co, output logic ovf);
        logic [W-1:0] bp;
        logic [W:0]   u;
        logic [W+1:0] wide, back;
        bp   = sub ? ~b : b;
        u    = {1'b0, a} + {1'b0, bp} + (W+1)'(ci);
        s    = u[W-1:0];
        co   = u[W];
        wide = {{2{a[W-1]}}, a} + {{2{bp[W-1]}}, bp} + (W+2)'(ci);
        back = {{2{s[W-1]}}, s};
        ovf  = (wide != back);
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '1;
            1:       v = '0;
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = {1'b1, {(W-1){1'b0}}};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic set_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic sub);
        if (id) begin
            r1_req = 1'b1; r1_a = a; r1_b = b; r1_ci = ci; r1_sub = sub;
        end else begin
            r0_req = 1'b1; r0_a = a; r0_b = b; r0_ci = ci; r0_sub = sub;
        end
    endtask

    task automatic wait_gnt(input logic id, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge nclk);
            if ((id ? r1_gnt : r0_gnt) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pulse_rst();
        @(posedge nclk); #1;
        rst = 1'b1; r0_req = 1'b0; r1_req = 1'b0; flush = 1'b0;
        @(posedge nclk); #1;
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge nclk);
        #1;
    endtask

    // One isolated operation: grant, NB quiet cycles, one response, then idle.
    task automatic run_op(input string nm, input logic id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic ci, input logic sub);
        logic [W-1:0] es;
        logic eco, eov;
        bit ok;
        model(a, b, ci, sub, es, eco, eov);
        @(posedge nclk); #1;
        r0_req = 1'b0; r1_req = 1'b0;
        set_req(id, a, b, ci, sub);
        wait_gnt(id, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s grant: no grant for r%0d within 40 cycles", nm, id);
            r0_req = 1'b0; r1_req = 1'b0;
            return;
        end
        total++;
        if ((id ? r0_gnt : r1_gnt) !== 1'b0) begin
            bad++;
            $display("FAIL %s other_gnt: got 1 want 0", nm);
        end
        @(posedge nclk); #1;
        if (id) begin r1_req = 1'b0; r1_a = rnd(); r1_b = rnd(); end
        else    begin r0_req = 1'b0; r0_a = rnd(); r0_b = rnd(); end
        for (int k = 1; k <= NB + 1; k++) begin
            @(negedge nclk);
            total++;
            if (k <= NB) begin
                if (rsp_val !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s run_k%0d: val=%b busy=%b want val=0 busy=1", nm, k, rsp_val, busy);
                end
            end else if (rsp_val !== 1'b1 || busy !== 1'b1 || rsp_id !== id ||
                         rsp_sum !== es || rsp_co !== eco || rsp_ovf !== eov) begin
                bad++;
                $display("FAIL %s rsp: val=%b id=%b sum=%h co=%b ovf=%b want val=1 id=%b sum=%h co=%b ovf=%b",
                         nm, rsp_val, rsp_id, rsp_sum, rsp_co, rsp_ovf, id, es, eco, eov);
            end
        end
        @(negedge nclk);
        total++;
        if (rsp_val !== 1'b0 || busy !== 1'b0 || rsp_sum !== es || rsp_id !== id) begin
            bad++;
            $display("FAIL %s after: val=%b busy=%b sum=%h id=%b want val=0 busy=0 sum=%h id=%b",
                     nm, rsp_val, busy, rsp_sum, rsp_id, es, id);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        set_req(0, rnd(), rnd(), 1'b1, 1'b0);
        set_req(1, rnd(), rnd(), 1'b1, 1'b1);
        repeat (2) @(negedge nclk);
        total++;
        if ({r0_gnt, r1_gnt, rsp_val, rsp_id, rsp_co, rsp_ovf, busy} !== 7'b0 || rsp_sum !== '0) begin
            bad++;
            $display("FAIL reset: gnt=%b%b val=%b id=%b co=%b ovf=%b busy=%b sum=%h want all 0",
                     r0_gnt, r1_gnt, rsp_val, rsp_id, rsp_co, rsp_ovf, busy, rsp_sum);
        end
        @(posedge nclk); #1;
        r0_req = 1'b0; r1_req = 1'b0; rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op("carry_byte", 1'b0, 64'h0000_0000_0000_00FF, 64'h1, 1'b0, 1'b0);
        run_op("wrap",       1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        run_op("ovf",        1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        run_op("sub",        1'b0, 64'h5, 64'h7, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            run_op("rand", 1'($urandom_range(0, 1)), rnd(), rnd(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Both requesters always pending: grants must alternate every NB+2 cycles.
    task automatic test_back_to_back();
        logic [W-1:0] qs[$];
        logic         qid[$], qco[$], qov[$];
        logic [W-1:0] es;
        logic         eco, eov, exp_id, gid, granted;
        int           ngr, last;
        pulse_rst();
        set_req(0, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        set_req(1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        exp_id = 1'b0; ngr = 0; last = 0; gid = 1'b0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge nclk);
            granted = 1'b0;
            if (rsp_val === 1'b1) begin
                total++;
                if (qs.size() == 0) begin
                    bad++;
                    $display("FAIL b2b rsp: unexpected response id=%b", rsp_id);
                end else begin
                    if (rsp_id !== qid[0] || rsp_sum !== qs[0] || rsp_co !== qco[0] || rsp_ovf !== qov[0]) begin
                        bad++;
                        $display("FAIL b2b rsp: id=%b sum=%h co=%b ovf=%b want id=%b sum=%h co=%b ovf=%b",
                                 rsp_id, rsp_sum, rsp_co, rsp_ovf, qid[0], qs[0], qco[0], qov[0]);
                    end
                    void'(qs.pop_front()); void'(qid.pop_front());
                    void'(qco.pop_front()); void'(qov.pop_front());
                end
            end
            if (r0_gnt === 1'b1 || r1_gnt === 1'b1) begin
                total++;
                if ((r0_gnt & r1_gnt) || r1_gnt !== exp_id || (ngr > 0 && cyc - last != NB + 2)) begin
                    bad++;
                    $display("FAIL b2b gnt: cyc=%0d gnt=%b%b gap=%0d want id=%b gap=%0d",
                             cyc, r1_gnt, r0_gnt, cyc - last, exp_id, NB + 2);
                end
                gid = r1_gnt;
                if (gid) model(r1_a, r1_b, r1_ci, r1_sub, es, eco, eov);
                else     model(r0_a, r0_b, r0_ci, r0_sub, es, eco, eov);
                qs.push_back(es); qid.push_back(gid); qco.push_back(eco); qov.push_back(eov);
                exp_id = ~exp_id; last = cyc; ngr++; granted = 1'b1;
            end
            @(posedge nclk); #1;
            if (granted)
                set_req(gid, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        total++;
        if (ngr < 4) begin
            bad++;
            $display("FAIL b2b count: grants=%0d want >=4", ngr);
        end
        r0_req = 1'b0; r1_req = 1'b0;
        idle_cycles(NB + 4);
    endtask

    // Flush at beat 4 hands the next tie to the other requester; reset mid-run
    // drops the operation and restores r0 priority.
    task automatic test_flush_rst();
        logic [W-1:0] a0, b0, es;
        logic         eco, eov;
        bit           ok;
        int           nv;
        pulse_rst();
        a0 = rnd(); b0 = rnd();
        set_req(0, a0, b0, 1'b0, 1'b0);
        wait_gnt(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL flush gnt0: no grant"); end
        @(posedge nclk); #1;
        repeat (4) @(posedge nclk);
        #1;
        flush = 1'b1;
        set_req(1, rnd(), rnd(), 1'b0, 1'b0);
        @(negedge nclk);
        total++;
        if (rsp_val !== 1'b0 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL flush beat4: val=%b gnt=%b%b busy=%b want 0 00 1", rsp_val, r1_gnt, r0_gnt, busy);
        end
        @(posedge nclk); #1;
        flush = 1'b0;
        @(negedge nclk);
        total++;
        if (busy !== 1'b0 || r1_gnt !== 1'b1 || r0_gnt !== 1'b0 || rsp_val !== 1'b0) begin
            bad++;
            $display("FAIL flush next: busy=%b gnt=%b%b val=%b want busy=0 gnt=10 val=0",
                     busy, r1_gnt, r0_gnt, rsp_val);
        end
        @(posedge nclk); #1;
        repeat (2) @(posedge nclk);
        #1;
        rst = 1'b1;
        @(negedge nclk);
        total++;
        if (rsp_val !== 1'b0 || busy !== 1'b0 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin
            bad++;
            $display("FAIL rst mid: val=%b busy=%b gnt=%b%b want 0 0 00", rsp_val, busy, r1_gnt, r0_gnt);
        end
        @(posedge nclk); #1;
        rst = 1'b0; r0_req = 1'b1; r1_req = 1'b1;
        @(negedge nclk);
        total++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
            bad++;
            $display("FAIL rst prio: gnt=%b%b want 01", r1_gnt, r0_gnt);
        end
        @(posedge nclk); #1;
        r0_req = 1'b0; r1_req = 1'b0;
        model(a0, b0, 1'b0, 1'b0, es, eco, eov);
        nv = 0;
        for (int k = 1; k <= NB + 3; k++) begin
            @(negedge nclk);
            if (rsp_val === 1'b1) begin
                nv++;
                total++;
                if (k != NB + 1 || rsp_id !== 1'b0 || rsp_sum !== es || rsp_co !== eco || rsp_ovf !== eov) begin
                    bad++;
                    $display("FAIL rst resume: k=%0d id=%b sum=%h co=%b want k=%0d id=0 sum=%h co=%b",
                             k, rsp_id, rsp_sum, rsp_co, NB + 1, es, eco);
                end
            end
        end
        total++;
        if (nv != 1) begin
            bad++;
            $display("FAIL rst resume count: responses=%0d want 1", nv);
        end
    endtask

    // Flush landing on DONE kills that response; flush in IDLE blocks grants
    // without moving the pointer.
    task automatic test_flush_done_idle();
        bit ok;
        @(posedge nclk); #1;
        set_req(0, rnd(), rnd(), 1'b0, 1'b0);
        wait_gnt(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL fdone gnt: no grant"); end
        @(posedge nclk); #1;
        r0_req = 1'b0;
        repeat (NB) @(posedge nclk);
        #1;
        flush = 1'b1;
        set_req(0, rnd(), rnd(), 1'b0, 1'b0);
        set_req(1, rnd(), rnd(), 1'b0, 1'b0);
        @(negedge nclk);
        total++;
        if (rsp_val !== 1'b0 || busy !== 1'b1 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin
            bad++;
            $display("FAIL fdone: val=%b busy=%b gnt=%b%b want 0 1 00", rsp_val, busy, r1_gnt, r0_gnt);
        end
        @(posedge nclk); #1;
        @(negedge nclk);
        total++;
        if (busy !== 1'b0 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || rsp_val !== 1'b0) begin
            bad++;
            $display("FAIL fidle: busy=%b gnt=%b%b val=%b want 0 00 0", busy, r1_gnt, r0_gnt, rsp_val);
        end
        @(posedge nclk); #1;
        flush = 1'b0;
        @(negedge nclk);
        total++;
        if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0) begin
            bad++;
            $display("FAIL fidle ptr: gnt=%b%b want 10", r1_gnt, r0_gnt);
        end
        @(posedge nclk); #1;
        r0_req = 1'b0; r1_req = 1'b0;
        idle_cycles(NB + 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        r0_req = 1'b0; r0_a = '0; r0_b = '0; r0_ci = 1'b0; r0_sub = 1'b0;
        r1_req = 1'b0; r1_a = '0; r1_b = '0; r1_ci = 1'b0; r1_sub = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush_rst();
        test_flush_done_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
